// File: rtl/decode_scan.sv
// decode_scan: registered N-to-2^N one-hot decoder with an auto-scan mode.
// In direct mode the channel follows sel_i. In scan mode an internal index
// starts at sel_i and advances one channel every DWELL enabled cycles,
// wrapping at OUT_W-1. ACTIVE_LOW inverts the channel output at the port.
//
// Ports:
//   clk_i   system clock, rising edge
//   rst_i   synchronous reset, active-high
//   en_i    enable; 0 blanks out_o and freezes scan state
//   mode_i  0 = direct decode of sel_i, 1 = auto-scan
//   sel_i   channel select (direct) / start channel on scan entry
//   out_o   registered one-hot (one-cold if ACTIVE_LOW) channel output
//   idx_o   registered index of the active channel
//   tick_o  one-cycle pulse: scan index advanced
//   wrap_o  one-cycle pulse: scan index advanced from OUT_W-1 to 0
module decode_scan #(
   parameter int unsigned SEL_W      = 4,
   parameter int unsigned DWELL      = 1000,
   parameter int unsigned ACTIVE_LOW = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  mode_i,
   input  logic [SEL_W-1:0]      sel_i,
   output logic [(2**SEL_W)-1:0] out_o,
   output logic [SEL_W-1:0]      idx_o,
   output logic                  tick_o,
   output logic                  wrap_o
);

   localparam int unsigned OUT_W = 2**SEL_W;
   localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   // All-inactive output pattern; also used as the polarity XOR mask.
   localparam logic [OUT_W-1:0] OUT_IDLE = {OUT_W{(ACTIVE_LOW != 0)}};
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

   logic [SEL_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;

   // Polarity-adjusted one-hot decode of a channel index.
   function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] i);
      logic [OUT_W-1:0] oh;
      oh = OUT_W'(1) << i;
      return oh ^ OUT_IDLE;
   endfunction

   // Next-state logic; en_i=0 leaves idx/cnt/mode held and output blanked.
   always_comb begin
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      out_d  = OUT_IDLE;
      tick_d = 1'b0;
      wrap_d = 1'b0;
      if (en_i) begin
         if (!mode_i || !mode_q) begin
            // Direct decode, or first scan cycle: load from sel_i.
            idx_d  = sel_i;
            cnt_d  = '0;
            mode_d = mode_i;
            out_d  = decode(sel_i);
         end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
            out_d = decode(idx_q);
         end else begin
            // Index width equals log2(OUT_W), so the increment wraps naturally.
            cnt_d  = '0;
            idx_d  = idx_q + SEL_W'(1);
            out_d  = decode(idx_q + SEL_W'(1));
            tick_d = 1'b1;
            wrap_d = (idx_q == IDX_LAST);
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q  <= '0;
         cnt_q  <= '0;
         mode_q <= 1'b0;
         out_q  <= OUT_IDLE;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
         out_q  <= out_d;
         tick_q <= tick_d;
         wrap_q <= wrap_d;
      end
   end

   assign out_o  = out_q;
   assign idx_o  = idx_q;
   assign tick_o = tick_q;
   assign wrap_o = wrap_q;

endmodule
